// File: rtl/mips_instr_encoder.sv
// Program loader: packs mnemonic-level requests into MIPS words, queues them and streams them into IM.
// Optional macro DELAY_SLOT_NOP_EN appends a zero word after every jump/branch word.
module mips_instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               busy_q, done_q;
  logic               session_clear;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d, push_cnt;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    wc_q, wc_d;
  logic               err_illegal_q, err_illegal_d, err_ovf_q, err_ovf_d;
  logic [31:0]        fifo_mem [FIFO_DEPTH];

  logic [5:0]  op, funct;
  logic [4:0]  f_rs, f_rt, f_rd, f_sh;
  logic        kind_r, kind_j, kind_legal;
  logic [31:0] enc_word;
  logic        active, fifo_full, head_valid, cap_full, pop, accept, push_word, room_ok;

  // Encoder: field forcing mirrors what the decoder ignores for each kind.
  always_comb begin
    op         = 6'h00;
    funct      = 6'h00;
    f_rs       = in_rs;
    f_rt       = in_rt;
    f_rd       = in_rd;
    f_sh       = 5'd0;
    kind_legal = 1'b1;
    case (in_kind)
      5'd0:  funct = 6'h20;
      5'd1:  funct = 6'h21;
      5'd2:  funct = 6'h22;
      5'd3:  funct = 6'h23;
      5'd4:  funct = 6'h24;
      5'd5:  funct = 6'h25;
      5'd6:  funct = 6'h27;
      5'd7:  funct = 6'h2A;
      5'd8:  funct = 6'h2B;
      5'd9:  begin funct = 6'h00; f_rs = 5'd0; f_sh = in_shamt; end
      5'd10: begin funct = 6'h02; f_rs = 5'd0; f_sh = in_shamt; end
      5'd11: funct = 6'h04;
      5'd12: funct = 6'h06;
      5'd13: begin funct = 6'h08; f_rt = 5'd0; f_rd = 5'd0; end
      5'd14: begin funct = 6'h09; f_rt = 5'd0; end
      5'd15: op = 6'h08;
      5'd16: op = 6'h0A;
      5'd17: op = 6'h0C;
      5'd18: op = 6'h0D;
      5'd19: begin op = 6'h0F; f_rs = 5'd0; end
      5'd20: op = 6'h23;
      5'd21: op = 6'h2B;
      5'd22: op = 6'h04;
      5'd23: op = 6'h05;
      5'd24: op = 6'h02;
      5'd25: op = 6'h03;
      default: kind_legal = 1'b0;
    endcase
    kind_r = (in_kind <= 5'd14);
    kind_j = (in_kind == 5'd24) || (in_kind == 5'd25);
    if (kind_j)
      enc_word = {op, in_target};
    else if (kind_r)
      enc_word = {6'h00, f_rs, f_rt, f_rd, f_sh, funct};
    else
      enc_word = {op, f_rs, f_rt, in_imm};
  end

  assign active     = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_valid = active && (count_q != '0);
  assign cap_full   = (wc_q == CAPACITY);
  // Past capacity the head is discarded rather than written, so the session still drains.
  assign pop        = head_valid && (cap_full || im_ready);
  assign im_we      = head_valid && !cap_full;
  assign in_ready   = (state_q == S_LOAD) && !fifo_full && room_ok;
  assign accept     = in_valid && in_ready;
  assign push_word  = accept && kind_legal;

`ifdef DELAY_SLOT_NOP_EN
  logic             kind_branch, push_nop;
  logic [PTR_W-1:0] wr_ptr_p1;
  assign kind_branch = (in_kind == 5'd13) || (in_kind == 5'd14) || (in_kind == 5'd22) ||
                       (in_kind == 5'd23) || (in_kind == 5'd24) || (in_kind == 5'd25);
  assign room_ok     = !kind_branch || (count_q <= CNT_W'(FIFO_DEPTH - 2));
  assign push_nop    = push_word && kind_branch;
  assign wr_ptr_p1   = wr_ptr_q + PTR_W'(1);
  always_comb begin
    push_cnt = '0;
    if (push_nop)
      push_cnt = CNT_W'(2);
    else if (push_word)
      push_cnt = CNT_W'(1);
  end
`else
  assign room_ok = 1'b1;
  always_comb begin
    push_cnt = '0;
    if (push_word)
      push_cnt = CNT_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (push_word)
      fifo_mem[wr_ptr_q] <= enc_word;
`ifdef DELAY_SLOT_NOP_EN
    if (push_nop)
      fifo_mem[wr_ptr_p1] <= 32'h0000_0000;
`endif
  end

  always_comb begin
    state_d       = state_q;
    session_clear = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_LOAD;
          session_clear = 1'b1;
        end
      end
      S_LOAD:  if (finish) state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + push_cnt[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + push_cnt - CNT_W'(pop);

    addr_d        = addr_q;
    wc_d          = wc_q;
    err_illegal_d = err_illegal_q;
    err_ovf_d     = err_ovf_q;
    if (session_clear) begin
      addr_d        = '0;
      wc_d          = '0;
      err_illegal_d = 1'b0;
      err_ovf_d     = 1'b0;
    end else begin
      if (im_we && im_ready) begin
        wc_d = wc_q + (ADDR_W+1)'(1);
        if (addr_q != ADDR_MAX)
          addr_d = addr_q + ADDR_W'(1);
      end
      if (pop && cap_full)
        err_ovf_d = 1'b1;
      if (accept && !kind_legal)
        err_illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      addr_q        <= '0;
      wc_q          <= '0;
      err_illegal_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d == S_LOAD) || (state_d == S_DRAIN);
      done_q        <= (state_d == S_DONE);
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      wc_q          <= wc_d;
      err_illegal_q <= err_illegal_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  assign im_addr     = addr_q;
  assign im_wdata    = im_we ? fifo_mem[rd_ptr_q] : 32'h0000_0000;
  assign busy        = busy_q;
  assign done        = done_q;
  assign word_count  = wc_q;
  assign err_illegal = err_illegal_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder; a second instance with ADDR_W=2 shares the stimulus for capacity overflow.
module tb_mips_instr_encoder;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst, start, finish, in_valid, im_ready;
  logic [4:0]  in_kind, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic          in_ready, im_we, busy, done, err_illegal, err_ovf;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   word_count;

  logic        s_in_ready, s_im_we, s_busy, s_done, s_err_illegal, s_err_ovf;
  logic [1:0]  s_im_addr;
  logic [31:0] s_im_wdata;
  logic [2:0]  s_word_count;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .word_count(word_count),
    .err_illegal(err_illegal), .err_ovf(err_ovf)
  );

  mips_instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .im_we(s_im_we), .im_ready(im_ready), .im_addr(s_im_addr), .im_wdata(s_im_wdata),
    .busy(s_busy), .done(s_done), .word_count(s_word_count),
    .err_illegal(s_err_illegal), .err_ovf(s_err_ovf)
  );

  // Write log of every completed IM handshake.
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  int            s_writes = 0;
  logic [1:0]    s_last_addr = 2'd0;

  always @(posedge clk) begin
    if (!rst && im_we && im_ready) begin
      log_addr.push_back(im_addr);
      log_data.push_back(im_wdata);
      $display("  write addr=%0d data=0x%08h", im_addr, im_wdata);
    end
    if (!rst && s_im_we && im_ready) begin
      s_writes    <= s_writes + 1;
      s_last_addr <= s_im_addr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [25:0] tgt);
    int n;
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_r(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh);
    send(k, rs, rt, rd, sh, 16'h0, 26'h0);
  endtask

  task automatic send_i(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [15:0] imm);
    send(k, rs, rt, 5'd0, 5'd0, imm, 26'h0);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; @(posedge clk); #1; finish = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int s_base;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    logic          stable;
    logic [31:0]   exp7[$];

    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; im_ready = 1'b1;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_im_we", 64'(im_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_wc", 64'(word_count), 64'd0);
    check("idle_errs", 64'({err_illegal, err_ovf}), 64'd0);
    @(posedge clk); #1;

    // Single add, one-cycle latency to im_we.
    base = log_data.size();
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    send_r(5'd0, 5'd1, 5'd2, 5'd3, 5'd0);
    check("t1_im_we", 64'(im_we), 64'd1);
    check("t1_addr", 64'(im_addr), 64'd0);
    check("t1_data", 64'(im_wdata), 64'h00221820);
    pulse_finish();
    wait_done();
    check("t1_wc", 64'(word_count), 64'd1);
    check("t1_busy_done", 64'(busy), 64'd0);
    check("t1_ready_done", 64'(in_ready), 64'd0);
    check("t1_nlog", 64'(log_data.size() - base), 64'd1);
    check("t1_log", 64'({log_addr[base], log_data[base]}), {32'd0, 32'h00221820});

    // lui (rs forced to 0), sw, jal.
    base = log_data.size();
    pulse_start();
    check("t2_wc_clear", 64'(word_count), 64'd0);
    send_i(5'd19, 5'd7, 5'd1, 16'h1234);
    send_i(5'd21, 5'd29, 5'd8, 16'hFFFC);
    send(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
    pulse_finish();
    wait_done();
    check("t2_wc", 64'(word_count), 64'd3);
    check("t2_lui", 64'({log_addr[base], log_data[base]}), {32'd0, 32'h3C011234});
    check("t2_sw", 64'({log_addr[base+1], log_data[base+1]}), {32'd1, 32'hAFA8FFFC});
    check("t2_jal", 64'({log_addr[base+2], log_data[base+2]}), {32'd2, 32'h0C100000});

    // Backpressure: FIFO fills after 4 accepts, head stays stable.
    base = log_data.size();
    pulse_start();
    im_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_i(5'd15, 5'd0, 5'(i), 16'(i));
    in_kind = 5'd15; in_rs = 5'd0; in_rt = 5'd5; in_imm = 16'd5; in_valid = 1'b1;
    @(negedge clk);
    check("t3_full_ready", 64'(in_ready), 64'd0);
    a0 = im_addr; d0 = im_wdata; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (im_addr !== a0 || im_wdata !== d0 || im_we !== 1'b1) stable = 1'b0;
    end
    check("t3_stable", 64'(stable), 64'd1);
    check("t3_head", 64'({a0, d0}), {22'd0, 10'd0, 32'h20010001});
    check("t3_still_full", 64'(in_ready), 64'd0);
    im_ready = 1'b1;
    send_i(5'd15, 5'd0, 5'd5, 16'd5);
    send_i(5'd15, 5'd0, 5'd6, 16'd6);
    pulse_finish();
    wait_done();
    check("t3_wc", 64'(word_count), 64'd6);
    check("t3_nlog", 64'(log_data.size() - base), 64'd6);
    for (int i = 1; i <= 6; i++)
      check($sformatf("t3_w%0d", i), 64'({log_addr[base+i-1], log_data[base+i-1]}),
            {32'(i - 1), 32'h20000000 | (32'(i) << 16) | 32'(i)});

    // Illegal kind between two valid requests.
    base = log_data.size();
    pulse_start();
    send_r(5'd0, 5'd1, 5'd2, 5'd3, 5'd0);
    send_r(5'd27, 5'd1, 5'd2, 5'd3, 5'd0);
    check("t4_err_illegal", 64'(err_illegal), 64'd1);
    send_r(5'd2, 5'd1, 5'd2, 5'd3, 5'd0);
    pulse_finish();
    wait_done();
    check("t4_wc", 64'(word_count), 64'd2);
    check("t4_nlog", 64'(log_data.size() - base), 64'd2);
    check("t4_w0", 64'({log_addr[base], log_data[base]}), {32'd0, 32'h00221820});
    check("t4_w1", 64'({log_addr[base+1], log_data[base+1]}), {32'd1, 32'h00221822});

    // Capacity overflow on the ADDR_W=2 instance.
    s_base = s_writes;
    pulse_start();
    check("t5_illegal_clear", 64'(err_illegal), 64'd0);
    check("t5_s_wc_clear", 64'(s_word_count), 64'd0);
    for (int i = 1; i <= 5; i++) send_i(5'd15, 5'd0, 5'(i), 16'(i));
    pulse_finish();
    wait_done();
    check("t5_s_done", 64'(s_done), 64'd1);
    check("t5_s_wc", 64'(s_word_count), 64'd4);
    check("t5_s_ovf", 64'(s_err_ovf), 64'd1);
    check("t5_s_writes", 64'(s_writes - s_base), 64'd4);
    check("t5_s_last_addr", 64'(s_last_addr), 64'd3);
    check("t5_main_ovf", 64'(err_ovf), 64'd0);
    check("t5_main_wc", 64'(word_count), 64'd5);
    pulse_start();
    check("t5_s_ovf_clear", 64'(s_err_ovf), 64'd0);
    check("t5_s_addr_clear", 64'(s_im_addr), 64'd0);
    pulse_finish();
    wait_done();

    // Reset during DRAIN with queued words.
    pulse_start();
    im_ready = 1'b0;
    send_r(5'd0, 5'd1, 5'd2, 5'd3, 5'd0);
    send_r(5'd0, 5'd1, 5'd2, 5'd4, 5'd0);
    send_r(5'd0, 5'd1, 5'd2, 5'd5, 5'd0);
    pulse_finish();
    @(negedge clk);
    check("t6_drain_busy", 64'(busy), 64'd1);
    check("t6_drain_we", 64'(im_we), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_we", 64'(im_we), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    im_ready = 1'b1;
    base = log_data.size();
    pulse_start();
    send_r(5'd1, 5'd4, 5'd5, 5'd6, 5'd0);
    pulse_finish();
    wait_done();
    check("t6_nlog", 64'(log_data.size() - base), 64'd1);
    check("t6_w0", 64'({log_addr[base], log_data[base]}), {32'd0, 32'h00853021});

    // Branch-class words, with or without delay-slot padding.
    base = log_data.size();
    pulse_start();
    send_i(5'd22, 5'd1, 5'd2, 16'h0003);
    send_r(5'd9, 5'd3, 5'd2, 5'd4, 5'd5);
    send(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    send_r(5'd13, 5'd31, 5'd5, 5'd6, 5'd3);
    pulse_finish();
    wait_done();
`ifdef DELAY_SLOT_NOP_EN
    exp7 = '{32'h10220003, 32'h0, 32'h00022140, 32'h08000010, 32'h0, 32'h03E00008, 32'h0};
`else
    exp7 = '{32'h10220003, 32'h00022140, 32'h08000010, 32'h03E00008};
`endif
    check("t7_wc", 64'(word_count), 64'(exp7.size()));
    check("t7_nlog", 64'(log_data.size() - base), 64'(exp7.size()));
    for (int i = 0; i < exp7.size(); i++)
      check($sformatf("t7_w%0d", i), 64'({log_addr[base+i], log_data[base+i]}),
            {32'(i), exp7[i]});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
